// File: rtl/airlock_sequencer.sv
// Single-chamber airlock sequencer: interlocked door/pressure FSM with one shared seconds timer.
// Optional abort of a running sequence is built when AIRLOCK_ABORT_EN is defined.
module airlock_sequencer #(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned FILL_SEC = 7,
    parameter int unsigned EVAC_SEC = 8,
    parameter int unsigned TW       = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          arrive_req_i,
    input  logic          depart_req_i,
    input  logic          outer_sw_i,
    input  logic          inner_sw_i,
    input  logic          fill_req_i,
    input  logic          evac_req_i,
    input  logic          abort_req_i,
    output logic          outer_open_o,
    output logic          inner_open_o,
    output logic          pressurized_o,
    output logic          evacuated_o,
    output logic          busy_o,
    output logic [TW-1:0] countdown_o,
    output logic          arrive_pend_o,
    output logic          depart_pend_o,
    output logic          reject_o
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE_EVAC, IDLE_PRESS, FILLING, EVACUATING} state_e;

    state_e          state_q, state_d;
    logic            outer_q, outer_d, inner_q, inner_d;
    logic            press_q, press_d, evac_q, evac_d, busy_q, busy_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pre_q, pre_d;
    logic            ap_q, ap_d, dp_q, dp_d, reject_q, reject_d;
    logic            primed_q, outer_sw_q, inner_sw_q, arrive_q, depart_q;

    logic outer_edge, inner_edge, arrive_edge, depart_edge;
    logic tick, last, doors_closed, abort_busy, abort_idle;
    logic arrive_set, depart_set;

    // Edge detection is suppressed until the first post-reset clock has sampled the levels
    assign outer_edge   = primed_q & (outer_sw_i ^ outer_sw_q);
    assign inner_edge   = primed_q & (inner_sw_i ^ inner_sw_q);
    assign arrive_edge  = primed_q & arrive_req_i & ~arrive_q;
    assign depart_edge  = primed_q & depart_req_i & ~depart_q;
    assign tick         = (pre_q == PW'(TICK_DIV - 1));
    assign last         = tick & (cnt_q == TW'(1));
    assign doors_closed = ~outer_q & ~inner_q;

`ifdef AIRLOCK_ABORT_EN
    assign abort_busy = abort_req_i;
    assign abort_idle = abort_req_i;
`else
    logic unused_abort;
    assign unused_abort = abort_req_i;
    assign abort_busy   = 1'b0;
    assign abort_idle   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE_EVAC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE_EVAC:  if (fill_req_i && doors_closed) state_d = FILLING;
            IDLE_PRESS: if (evac_req_i && doors_closed) state_d = EVACUATING;
            FILLING: begin
                if (abort_busy)  state_d = IDLE_EVAC;
                else if (last)   state_d = IDLE_PRESS;
            end
            EVACUATING: begin
                if (abort_busy)  state_d = IDLE_PRESS;
                else if (last)   state_d = IDLE_EVAC;
            end
            default: state_d = IDLE_EVAC;
        endcase
    end

    always_comb begin
        outer_d  = outer_q;
        inner_d  = inner_q;
        cnt_d    = cnt_q;
        pre_d    = pre_q;
        reject_d = 1'b0;
        case (state_q)
            IDLE_EVAC: begin
                reject_d = evac_req_i | inner_edge | (fill_req_i & ~doors_closed) | abort_idle;
                if (state_d == FILLING) begin
                    cnt_d    = TW'(FILL_SEC);
                    pre_d    = '0;
                    reject_d = reject_d | outer_edge;
                end else if (outer_edge) begin
                    outer_d = ~outer_q;
                end
            end
            IDLE_PRESS: begin
                reject_d = fill_req_i | outer_edge | (evac_req_i & ~doors_closed) | abort_idle;
                if (state_d == EVACUATING) begin
                    cnt_d    = TW'(EVAC_SEC);
                    pre_d    = '0;
                    reject_d = reject_d | inner_edge;
                end else if (inner_edge) begin
                    inner_d = ~inner_q;
                end
            end
            default: begin
                reject_d = outer_edge | inner_edge | fill_req_i | evac_req_i;
                if (abort_busy) begin
                    cnt_d = '0;
                    pre_d = '0;
                end else if (tick) begin
                    pre_d = '0;
                    cnt_d = cnt_q - TW'(1);
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        endcase

        press_d = (state_d == IDLE_PRESS);
        evac_d  = (state_d == IDLE_EVAC);
        busy_d  = (state_d == FILLING) || (state_d == EVACUATING);

        // A pending flag blocks the other request; arrive wins a simultaneous rise
        arrive_set = arrive_edge & ~dp_q;
        depart_set = depart_edge & ~ap_q & ~arrive_set;
        ap_d = (ap_q & ~(outer_q & ~outer_d)) | arrive_set;
        dp_d = (dp_q & ~(inner_q & ~inner_d)) | depart_set;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outer_q    <= 1'b0;
            inner_q    <= 1'b0;
            press_q    <= 1'b0;
            evac_q     <= 1'b1;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            pre_q      <= '0;
            ap_q       <= 1'b0;
            dp_q       <= 1'b0;
            reject_q   <= 1'b0;
            primed_q   <= 1'b0;
            outer_sw_q <= 1'b0;
            inner_sw_q <= 1'b0;
            arrive_q   <= 1'b0;
            depart_q   <= 1'b0;
        end else begin
            outer_q    <= outer_d;
            inner_q    <= inner_d;
            press_q    <= press_d;
            evac_q     <= evac_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            ap_q       <= ap_d;
            dp_q       <= dp_d;
            reject_q   <= reject_d;
            primed_q   <= 1'b1;
            outer_sw_q <= outer_sw_i;
            inner_sw_q <= inner_sw_i;
            arrive_q   <= arrive_req_i;
            depart_q   <= depart_req_i;
        end
    end

    assign outer_open_o  = outer_q;
    assign inner_open_o  = inner_q;
    assign pressurized_o = press_q;
    assign evacuated_o   = evac_q;
    assign busy_o        = busy_q;
    assign countdown_o   = cnt_q;
    assign arrive_pend_o = ap_q;
    assign depart_pend_o = dp_q;
    assign reject_o      = reject_q;

endmodule

// File: tb/tb_airlock_sequencer.sv
// Bench for airlock_sequencer: directed vector table, hand sequences and random stimulus vs a cycle-level model.
module tb_airlock_sequencer;

    localparam int TICK_DIV = 4;
    localparam int FILL_SEC = 7;
    localparam int EVAC_SEC = 8;
    localparam int TW       = 10;

    localparam int M_EVAC = 0;
    localparam int M_PRESS = 1;
    localparam int M_FILL = 2;
    localparam int M_EVACING = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic arrive = 1'b0, depart = 1'b0, osw = 1'b0, isw = 1'b0;
    logic fill = 1'b0, evac = 1'b0, abort = 1'b0;
    logic outer_o, inner_o, press_o, evac_o, busy_o, ap_o, dp_o, rej_o;
    logic [TW-1:0] cd_o;

    airlock_sequencer #(
        .TICK_DIV(TICK_DIV), .FILL_SEC(FILL_SEC), .EVAC_SEC(EVAC_SEC), .TW(TW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .arrive_req_i(arrive), .depart_req_i(depart),
        .outer_sw_i(osw), .inner_sw_i(isw),
        .fill_req_i(fill), .evac_req_i(evac), .abort_req_i(abort),
        .outer_open_o(outer_o), .inner_open_o(inner_o),
        .pressurized_o(press_o), .evacuated_o(evac_o), .busy_o(busy_o),
        .countdown_o(cd_o), .arrive_pend_o(ap_o), .depart_pend_o(dp_o),
        .reject_o(rej_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: chamber mode plus busy cycles remaining; countdown derived arithmetically
    int m_mode, m_rem;
    bit m_outer, m_inner, m_ap, m_dp, m_rej, m_primed;
    bit m_po, m_pi, m_pa, m_pd;

    task automatic model_reset();
        m_mode = M_EVAC; m_rem = 0;
        m_outer = 0; m_inner = 0; m_ap = 0; m_dp = 0; m_rej = 0; m_primed = 0;
        m_po = 0; m_pi = 0; m_pa = 0; m_pd = 0;
    endtask

    task automatic model_step();
        bit oe, ie, ar, dr, rej, ok, ab, aset, dset, o_old, i_old;
        int st;
        st = m_mode; o_old = m_outer; i_old = m_inner;
        oe = m_primed && (osw != m_po);
        ie = m_primed && (isw != m_pi);
        ar = m_primed && arrive && !m_pa;
        dr = m_primed && depart && !m_pd;
`ifdef AIRLOCK_ABORT_EN
        ab = abort;
`else
        ab = 0;
`endif
        rej = 0;
        if (st == M_EVAC) begin
            ok = fill && !m_outer && !m_inner;
            if (evac || ie || (fill && !ok) || ab) rej = 1;
            if (ok) begin
                m_mode = M_FILL; m_rem = FILL_SEC * TICK_DIV;
                if (oe) rej = 1;
            end else if (oe) m_outer = !m_outer;
        end else if (st == M_PRESS) begin
            ok = evac && !m_outer && !m_inner;
            if (fill || oe || (evac && !ok) || ab) rej = 1;
            if (ok) begin
                m_mode = M_EVACING; m_rem = EVAC_SEC * TICK_DIV;
                if (ie) rej = 1;
            end else if (ie) m_inner = !m_inner;
        end else begin
            if (oe || ie || fill || evac) rej = 1;
            if (ab) begin
                m_mode = (st == M_FILL) ? M_EVAC : M_PRESS; m_rem = 0;
            end else begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_mode = (st == M_FILL) ? M_PRESS : M_EVAC;
            end
        end
        aset = ar && !m_dp;
        dset = dr && !m_ap && !aset;
        if (o_old && !m_outer) m_ap = 0;
        if (i_old && !m_inner) m_dp = 0;
        if (aset) m_ap = 1;
        if (dset) m_dp = 1;
        m_rej = rej;
        m_po = osw; m_pi = isw; m_pa = arrive; m_pd = depart; m_primed = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_vec();
        return int'({outer_o, inner_o, press_o, evac_o, busy_o, ap_o, dp_o, rej_o, cd_o});
    endfunction

    function automatic int model_vec();
        bit mb;
        int cd;
        mb = (m_mode == M_FILL) || (m_mode == M_EVACING);
        cd = mb ? (m_rem + TICK_DIV - 1) / TICK_DIV : 0;
        return int'({m_outer, m_inner, m_mode == M_PRESS, m_mode == M_EVAC, mb,
                     m_ap, m_dp, m_rej, TW'(cd)});
    endfunction

    // One clock: model consumes the applied inputs, DUT is sampled 1ns after the edge
    task automatic cyc(input string name);
        model_step();
        @(posedge clk);
        #1;
        chk(name, dut_vec(), model_vec());
        fill = 0; evac = 0; abort = 0;
    endtask

    typedef struct {
        logic [5:0] in_v;   // arrive depart outer_sw inner_sw fill evac
        logic [4:0] st_v;   // outer inner pressurized evacuated busy
        int         cd;
        logic [2:0] pr_v;   // arrive_pend depart_pend reject
    } vec_t;

    function automatic vec_t mk(input logic [5:0] i, input logic [4:0] s, input int c,
                                input logic [2:0] p);
        vec_t v;
        v.in_v = i; v.st_v = s; v.cd = c; v.pr_v = p;
        return v;
    endfunction

    localparam int RESET_VEC = 32'h0_4000;   // evacuated=1, everything else 0

    vec_t tbl[12];
    int busy_n;

    initial begin
        tbl[0]  = mk(6'b000000, 5'b00010, 0, 3'b000);
        tbl[1]  = mk(6'b001000, 5'b10010, 0, 3'b000);
        tbl[2]  = mk(6'b001010, 5'b10010, 0, 3'b001);
        tbl[3]  = mk(6'b000000, 5'b00010, 0, 3'b000);
        tbl[4]  = mk(6'b000100, 5'b00010, 0, 3'b001);
        tbl[5]  = mk(6'b110100, 5'b00010, 0, 3'b100);
        tbl[6]  = mk(6'b111100, 5'b10010, 0, 3'b100);
        tbl[7]  = mk(6'b110100, 5'b00010, 0, 3'b000);
        tbl[8]  = mk(6'b110101, 5'b00010, 0, 3'b001);
        tbl[9]  = mk(6'b111110, 5'b00001, 7, 3'b001);
        tbl[10] = mk(6'b111100, 5'b00001, 7, 3'b000);
        tbl[11] = mk(6'b111000, 5'b00001, 7, 3'b001);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", dut_vec(), RESET_VEC);
        rst = 0;

        // Directed table; row 0 is the priming clock after reset release
        busy_n = 0;
        for (int k = 0; k < 12; k++) begin
            {arrive, depart, osw, isw, fill, evac} = tbl[k].in_v;
            cyc("table_model");
            chk($sformatf("table_row%0d", k),
                int'({outer_o, inner_o, press_o, evac_o, busy_o, ap_o, dp_o, rej_o, cd_o}),
                int'({tbl[k].st_v, tbl[k].pr_v, TW'(tbl[k].cd)}));
            if (busy_o) busy_n++;
        end

        // Fill runs to expiry: 28 busy cycles in total
        for (int k = 0; k < 60 && busy_o; k++) begin
            cyc("fill_run");
            if (busy_o) busy_n++;
        end
        chk("fill_busy_cycles", busy_n, FILL_SEC * TICK_DIV);
        chk("fill_done_press", int'({press_o, evac_o, cd_o}), int'({1'b1, 1'b0, TW'(0)}));

        // Evacuate with door edges refused mid-sequence
        evac = 1;
        cyc("evac_start");
        busy_n = busy_o ? 1 : 0;
        for (int k = 0; k < 80 && busy_o; k++) begin
            if (k == 5)  isw = ~isw;
            if (k == 12) osw = ~osw;
            cyc("evac_run");
            if (k == 5)  chk("evac_inner_reject", int'({rej_o, inner_o}), int'({1'b1, 1'b0}));
            if (k == 12) chk("evac_outer_reject", int'({rej_o, outer_o}), int'({1'b1, 1'b0}));
            if (busy_o) busy_n++;
        end
        chk("evac_busy_cycles", busy_n, EVAC_SEC * TICK_DIV);
        chk("evac_done", int'({evac_o, press_o, cd_o}), int'({1'b1, 1'b0, TW'(0)}));

        // Reset asserted mid-evacuate
        fill = 1;
        cyc("rst_fill");
        for (int k = 0; k < 60 && busy_o; k++) cyc("rst_fill_run");
        evac = 1;
        cyc("rst_evac");
        repeat (10) cyc("rst_evac_run");
        #2 rst = 1;
        #1;
        chk("mid_seq_reset", dut_vec(), RESET_VEC);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        cyc("post_reset_prime");

        // Random stimulus against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(15) == 0) arrive = ~arrive;
            if ($urandom_range(15) == 0) depart = ~depart;
            if ($urandom_range(9) == 0)  osw = ~osw;
            if ($urandom_range(9) == 0)  isw = ~isw;
            fill  = ($urandom_range(5) == 0);
            evac  = ($urandom_range(5) == 0);
            abort = ($urandom_range(31) == 0);
            cyc("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
